// File: rtl/inst_fetch_buffer.sv
// Fetch stage: single-outstanding req/gnt/rvalid fetch into a DEPTH-entry FWFT queue for decode.
// Define MISALIGN_CHECK_EN to turn misaligned PCs into fault entries instead of memory reads.
module inst_fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [XLEN-1:0]            pc_in,
    input  logic                       pc_valid,
    output logic                       pc_ready,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [ILEN-1:0]            imem_rdata,
    input  logic                       flush,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [ILEN-1:0]            id_instr,
    output logic                       id_fault,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_DATA, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]   mem_pc_q [DEPTH];
    logic [XLEN-1:0]   mem_pc_d [DEPTH];
    logic [ILEN-1:0]   mem_instr_q [DEPTH];
    logic [ILEN-1:0]   mem_instr_d [DEPTH];

    logic              outstanding, fault_pend, space, accept, take_fetch;
    logic              push_fetch, push_fault, push, pop;
    logic [CW:0]       used;
    logic [XLEN-1:0]   push_pc;
    logic [ILEN-1:0]   push_instr;

`ifdef MISALIGN_CHECK_EN
    logic              fault_pend_q, fault_pend_d, take_fault;
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
    logic              mem_flt_q [DEPTH];
    logic              mem_flt_d [DEPTH];

    assign take_fault = accept && (pc_in[1:0] != 2'b00);
    assign take_fetch = accept && (pc_in[1:0] == 2'b00);
    assign fault_pend = fault_pend_q;

    always_comb begin
        fault_pend_d = take_fault;
        fault_pc_d   = take_fault ? pc_in : fault_pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_pend_q <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            fault_pend_q <= fault_pend_d;
            fault_pc_q   <= fault_pc_d;
        end
    end
`else
    assign take_fetch = accept;
    assign fault_pend = 1'b0;
`endif

    // A pending fault entry holds a buffer slot just like an in-flight fetch.
    assign outstanding = (state_q == WAIT_GNT) || (state_q == WAIT_DATA);
    assign used        = {1'b0, count_q} + {{CW{1'b0}}, outstanding} + {{CW{1'b0}}, fault_pend};
    assign space       = used < (CW+1)'(DEPTH);
    assign pc_ready    = !reset && !flush && space &&
                         ((state_q == IDLE) || ((state_q == WAIT_DATA) && imem_rvalid));
    assign accept      = pc_valid && pc_ready;

    assign imem_req    = (state_q == WAIT_GNT);
    assign imem_addr   = req_pc_q;

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        push_fetch = 1'b0;
        if (flush) begin
            unique case (state_q)
                IDLE:      state_d = IDLE;
                WAIT_GNT:  state_d = imem_gnt ? DRAIN : IDLE;
                WAIT_DATA: state_d = imem_rvalid ? IDLE : DRAIN;
                DRAIN:     state_d = imem_rvalid ? IDLE : DRAIN;
                default:   state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take_fetch) begin
                        req_pc_d = pc_in;
                        state_d  = WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (imem_gnt) state_d = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (imem_rvalid) begin
                        push_fetch = 1'b1;
                        if (take_fetch) begin
                            req_pc_d = pc_in;
                            state_d  = WAIT_GNT;
                        end else begin
                            state_d  = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign push_fault = fault_pend_q && !flush;
    assign push_pc    = push_fault ? fault_pc_q : req_pc_q;
    assign push_instr = push_fault ? ILEN'(32'h0000_0013) : imem_rdata;
`else
    assign push_fault = 1'b0;
    assign push_pc    = req_pc_q;
    assign push_instr = imem_rdata;
`endif

    assign push = push_fetch || push_fault;
    assign pop  = id_valid && id_ready && !flush;

    always_comb begin
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;
`ifdef MISALIGN_CHECK_EN
        mem_flt_d   = mem_flt_q;
`endif
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]    = push_pc;
                mem_instr_d[wr_ptr_q] = push_instr;
`ifdef MISALIGN_CHECK_EN
                mem_flt_d[wr_ptr_q]   = push_fault;
`endif
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
`ifdef MISALIGN_CHECK_EN
                mem_flt_q[i]   <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
`ifdef MISALIGN_CHECK_EN
            mem_flt_q   <= mem_flt_d;
`endif
        end
    end

    // The credit check should make this unreachable.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && (count_q == CW'(DEPTH))));
    end

    assign count    = count_q;
    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? mem_pc_q[rd_ptr_q] : '0;
    assign id_instr = id_valid ? mem_instr_q[rd_ptr_q] : '0;
`ifdef MISALIGN_CHECK_EN
    assign id_fault = id_valid && mem_flt_q[rd_ptr_q];
`else
    assign id_fault = 1'b0;
`endif

endmodule
